muldiv_unit: RTL and testbench

- Iterative RISC-V M-extension execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Consumes the two register-file read-data outputs (rs1/rs2) and produces a write-back request (enable, rd, data) for the register-file write port.
- Sits between the register file read side and the write-back mux; stalls the core via busy_o while computing.

---
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_muldiv_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 radix-2 steps per op, 35 edges start-to-start.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier (divide stays iterative).
module muldiv_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic         kill_i,
    input  logic [2:0]   funct3_i,
    input  logic [N-1:0] rs1_data_i,
    input  logic [N-1:0] rs2_data_i,
    input  logic [4:0]   rd_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         reg_write_o,
    output logic [4:0]   write_register_o,
    output logic [N-1:0] write_data_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state, state_nxt;
    logic [2:0]     f3_q;
    logic [4:0]     rd_q;
    logic [4:0]     cnt_q;
    logic           steps_done_q;
    logic           neg_q_q, neg_r_q;
    logic [N-1:0]   opnd_q;
    logic [2*N-1:0] acc_q;
    logic [N-1:0]   result_q;

    // Operand decode at issue
    logic           sgn_a, sgn_b;
    logic [N-1:0]   mag_a, mag_b;
    logic           div_zero, div_ovf, special;
    logic [N-1:0]   special_res;
    logic           fast_hit;
    logic [N-1:0]   fast_res;

    assign sgn_a = rs1_data_i[N-1] & (funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
    assign sgn_b = rs2_data_i[N-1] & (funct3_i inside {3'd0, 3'd1, 3'd4, 3'd6});
    assign mag_a = sgn_a ? -rs1_data_i : rs1_data_i;
    assign mag_b = sgn_b ? -rs2_data_i : rs2_data_i;

    assign div_zero = funct3_i[2] & (rs2_data_i == '0);
    assign div_ovf  = funct3_i[2] & ~funct3_i[0] & (rs1_data_i == {1'b1, {(N-1){1'b0}}})
                      & (rs2_data_i == '1);
    assign special  = div_zero | div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = funct3_i[1] ? rs1_data_i : '1;
        else if (div_ovf)
            special_res = funct3_i[1] ? '0 : {1'b1, {(N-1){1'b0}}};
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*N-1:0] fast_mag, fast_prod;
    assign fast_mag  = {{N{1'b0}}, mag_a} * {{N{1'b0}}, mag_b};
    assign fast_prod = (sgn_a ^ sgn_b) ? -fast_mag : fast_mag;
    assign fast_hit  = ~funct3_i[2];
    assign fast_res  = (funct3_i == 3'd0) ? fast_prod[N-1:0] : fast_prod[2*N-1:N];
`else
    assign fast_hit  = 1'b0;
    assign fast_res  = '0;
`endif

    // One radix-2 step: shift-add for multiply, restoring subtract for divide
    logic [N:0]     mul_sum, div_tmp, div_diff;
    logic           div_ge;
    logic [2*N-1:0] acc_step;

    assign mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_tmp  = acc_q[2*N-1:N-1];
    assign div_diff = div_tmp - {1'b0, opnd_q};
    assign div_ge   = ~div_diff[N];
    assign acc_step = f3_q[2] ? {(div_ge ? div_diff[N-1:0] : div_tmp[N-1:0]), acc_q[N-2:0], div_ge}
                              : {mul_sum, acc_q[N-1:1]};

    // Sign correction applied as the result is latched on entry to DONE
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   quot_fix, rem_fix, final_res;

    assign prod_fix = neg_q_q ? -acc_q : acc_q;
    assign quot_fix = neg_q_q ? -acc_q[N-1:0] : acc_q[N-1:0];
    assign rem_fix  = neg_r_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];

    always_comb begin
        final_res = '0;
        case (f3_q)
            3'd0:          final_res = prod_fix[N-1:0];
            3'd1, 3'd2,
            3'd3:          final_res = prod_fix[2*N-1:N];
            3'd4, 3'd5:    final_res = quot_fix;
            default:       final_res = rem_fix;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = (special | fast_hit) ? DONE : CALC;
            CALC:    if (steps_done_q) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill_i)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            f3_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            steps_done_q <= 1'b0;
            neg_q_q      <= 1'b0;
            neg_r_q      <= 1'b0;
            opnd_q       <= '0;
            acc_q        <= '0;
            result_q     <= '0;
        end else begin
            state <= state_nxt;
            if (!kill_i) begin
                if (state == IDLE && start_i) begin
                    f3_q         <= funct3_i;
                    rd_q         <= rd_i;
                    cnt_q        <= 5'd31;
                    steps_done_q <= 1'b0;
                    neg_q_q      <= sgn_a ^ sgn_b;
                    neg_r_q      <= sgn_a;
                    opnd_q       <= funct3_i[2] ? mag_b : mag_a;
                    acc_q        <= {{N{1'b0}}, (funct3_i[2] ? mag_a : mag_b)};
                    result_q     <= special ? special_res : fast_res;
                end else if (state == CALC) begin
                    if (!steps_done_q) begin
                        acc_q <= acc_step;
                        if (cnt_q == 5'd0)
                            steps_done_q <= 1'b1;
                        else
                            cnt_q <= cnt_q - 5'd1;
                    end else begin
                        result_q <= final_res;
                    end
                end
            end
        end
    end

    assign busy_o           = (state != IDLE);
    assign done_o           = (state == DONE);
    assign reg_write_o      = done_o & (rd_q != 5'd0);
    assign write_register_o = rd_q;
    assign write_data_o     = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised + directed bench for muldiv_unit with a queued scoreboard and arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done, reg_write;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;

    muldiv_unit #(.N(32)) dut (
        .clk(clk), .reset(reset), .start_i(start), .kill_i(kill), .funct3_i(funct3),
        .rs1_data_i(rs1), .rs2_data_i(rs2), .rd_i(rd_in),
        .busy_o(busy), .done_o(done), .reg_write_o(reg_write),
        .write_register_o(wr_reg), .write_data_o(wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        int          due;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit / 32-bit arithmetic following the RV32M rules
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        int     ia, ib;
        ia = a;
        ib = b;
        case (f3)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                sa = (f3 != 3'd3) ? {{32{a[31]}}, a} : {32'b0, a};
                sb = (f3 <= 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
                p  = sa * sb;
                return (f3 == 3'd0) ? p[31:0] : p[63:32];
            end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 0;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 0;
`endif
        return 33;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset && done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.tag, "_data"}, wr_data, e.data);
                check({e.tag, "_rd"}, {27'b0, wr_reg}, {27'b0, e.rd});
                check({e.tag, "_we"}, {31'b0, reg_write}, {31'b0, e.we});
                check({e.tag, "_cycle"}, cyc, e.due);
            end
        end
    end

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int poke_at, input int kill_at);
        int   n0, d, fall;
        bit   fell;
        exp_t e;
        @(negedge clk);
        funct3 = f3; rs1 = a; rs2 = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        #1;
        n0 = cyc;
        start = 1'b0;
        rs1 = $urandom; rs2 = $urandom; rd_in = 5'($urandom); funct3 = 3'($urandom);
        d = latency(f3, a, b);
        if (kill_at == 0) begin
            e.data = model(f3, a, b);
            e.rd   = rd;
            e.we   = (rd != 0);
            e.due  = n0 + d;
            e.tag  = tag;
            q.push_back(e);
        end
        check({tag, "_busy_rise"}, {31'b0, busy}, 32'd1);
        fell = 1'b0;
        fall = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) begin
                fell = 1'b1;
                fall = cyc;
                break;
            end
            start = (poke_at != 0 && cyc == n0 + poke_at - 1);
            if (start) begin
                funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom; rd_in = 5'($urandom);
            end
            kill = (kill_at != 0 && cyc == n0 + kill_at - 1);
        end
        start = 1'b0;
        kill = 1'b0;
        check({tag, "_busy_fall"}, fell ? fall : -1, (kill_at != 0) ? n0 + kill_at : n0 + d + 1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(5, 0))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(20, 1);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_we", {31'b0, reg_write}, 32'd0);
        check("rst_rd", {27'b0, wr_reg}, 32'd0);
        check("rst_data", wr_data, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_op("mul_7x6",      3'd0, 32'd7, 32'd6, 5'd5, 0, 0);
        run_op("mulh_m1",      3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, 0);
        run_op("mulhu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, 0);
        run_op("mulhsu_m1x2",  3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 0, 0);
        run_op("div_m7_2",     3'd4, -32'sd7, 32'd2, 5'd4, 0, 0);
        run_op("rem_m7_2",     3'd6, -32'sd7, 32'd2, 5'd6, 0, 0);
        run_op("divu_100_7",   3'd5, 32'd100, 32'd7, 5'd7, 0, 0);
        run_op("remu_100_7",   3'd7, 32'd100, 32'd7, 5'd8, 0, 0);
        run_op("divu_by0",     3'd5, 32'd5, 32'd0, 5'd9, 0, 0);
        run_op("rem_by0",      3'd6, 32'd5, 32'd0, 5'd10, 0, 0);
        run_op("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 0);
        run_op("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, 0);
        run_op("mul_rd0_poke", 3'd0, 32'd3, 32'd3, 5'd0, 10, 0);
        run_op("divu_kill",    3'd5, 32'd1000, 32'd3, 5'd13, 0, 15);

        // Kill and start together in IDLE: start must be dropped
        @(negedge clk);
        funct3 = 3'd0; rs1 = 32'd2; rs2 = 32'd2; rd_in = 5'd14; start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill_start_idle", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);

        // Reset mid-operation clears everything immediately, no write-back afterwards
        @(negedge clk);
        funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; rd_in = 5'd21; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_we", {31'b0, reg_write}, 32'd0);
        check("midrst_rd", {27'b0, wr_reg}, 32'd0);
        check("midrst_data", wr_data, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [4:0] rdr;
            rdr = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
            run_op($sformatf("rand%0d", i), 3'($urandom_range(7, 0)), pick(), pick(), rdr, 0, 0);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
